// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
// Used by forward_unit, hazard_ctrl and the hazard_ctrl_if interface users.

package hazard_pkg;

   // Hazard controller FSM: normal issue, or frozen behind a data-memory access
   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   // EX-stage operand source select
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   // ResultSrc encoding that marks a load instruction
   localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

   // Width of the memory-wait counter; MEM_TIMEOUT must fit in it (<= 31)
   localparam int WAIT_CNT_W = 5;

   // True when a stage writing rd can supply source register rs (x0 never matches)
   function automatic logic reg_match(input logic [4:0] rd,
                                      input logic       we,
                                      input logic [4:0] rs);
      return we && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the pipeline-side signals of the hazard controller.
// slave modport is used by hazard_ctrl; master modport by the pipeline driving it.

interface hazard_ctrl_if #(
   parameter int WIDTH = 32
);
   logic [4:0]       Rs1_D;
   logic [4:0]       Rs2_D;
   logic [4:0]       Rs1_E;
   logic [4:0]       Rs2_E;
   logic [4:0]       Rd_E;
   logic [1:0]       ResultSrc_E;
   logic             PCtaken_E;
   logic [4:0]       Rd_M;
   logic             RegWrite_M;
   logic             MemReq_M;
   logic             MemReady_M;
   logic [4:0]       Rd_W;
   logic             RegWrite_W;

   logic             Stall_F;
   logic             Stall_D;
   logic             Stall_E;
   logic             Stall_M;
   logic             Flush_D;
   logic             Flush_E;
   logic             Flush_W;
   logic [1:0]       ForwardA_E;
   logic [1:0]       ForwardB_E;
   logic             MemErr;
   logic [WIDTH-1:0] StallCnt;
   logic [WIDTH-1:0] FlushCnt;

   modport slave (
      input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, PCtaken_E,
             Rd_M, RegWrite_M, MemReq_M, MemReady_M, Rd_W, RegWrite_W,
      output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
             ForwardA_E, ForwardB_E, MemErr, StallCnt, FlushCnt
   );

   modport master (
      output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, PCtaken_E,
             Rd_M, RegWrite_M, MemReq_M, MemReady_M, Rd_W, RegWrite_W,
      input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
             ForwardA_E, ForwardB_E, MemErr, StallCnt, FlushCnt
   );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// forward_unit: operand bypass select for one EX-stage source register.
// MEM-stage result is newer than WB, so it wins when both match.

module forward_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic       regwrite_m,
   input  logic [4:0] rd_w,
   input  logic       regwrite_w,
   output fwd_sel_t   fwd_sel
);

   // Pick the youngest producer of rs_e, falling back to the register file
   always_comb begin
      fwd_sel = FWD_RF;
      if (reg_match(rd_m, regwrite_m, rs_e)) begin
         fwd_sel = FWD_M;
      end else if (reg_match(rd_w, regwrite_w, rs_e)) begin
         fwd_sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the five-stage RV32I pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined;
// otherwise StallCnt/FlushCnt are tied to zero and no counter flops exist.

module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_CNT_W-1:0] CNT_MAX_C = '1;

   hz_state_t             state_q, state_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                  mem_err_q, mem_err_d;

   fwd_sel_t fwd_a, fwd_b;
   logic     mem_stall;
   logic     load_use;
   logic     stall_f, stall_d, stall_e, stall_m;
   logic     flush_d, flush_e, flush_w;

   forward_unit u_fwd_a (
      .rs_e       (hz.Rs1_E),
      .rd_m       (hz.Rd_M),
      .regwrite_m (hz.RegWrite_M),
      .rd_w       (hz.Rd_W),
      .regwrite_w (hz.RegWrite_W),
      .fwd_sel    (fwd_a)
   );

   forward_unit u_fwd_b (
      .rs_e       (hz.Rs2_E),
      .rd_m       (hz.Rd_M),
      .regwrite_m (hz.RegWrite_M),
      .rd_w       (hz.Rd_W),
      .regwrite_w (hz.RegWrite_W),
      .fwd_sel    (fwd_b)
   );

   // Hazard detection terms; load-use ignores x0 as the load destination
   always_comb begin
      mem_stall = hz.MemReq_M && !hz.MemReady_M;
      load_use  = (hz.ResultSrc_E == RESULTSRC_LOAD) && (hz.Rd_E != 5'd0) &&
                  ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
   end

   // FSM state, wait counter and sticky timeout flag (synchronous reset)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Next state and stall/flush outputs: reset > memory stall > branch > load-use
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      stall_m    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_w    = 1'b0;

      if (rst) begin
         flush_d    = 1'b1;
         flush_e    = 1'b1;
         flush_w    = 1'b1;
         state_d    = RUN;
         wait_cnt_d = '0;
         mem_err_d  = 1'b0;
      end else if (mem_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
         state_d = MEM_WAIT;
         if (state_q == RUN) begin
            wait_cnt_d = WAIT_CNT_W'(1);
         end else if (wait_cnt_q != CNT_MAX_C) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
         end
         if (wait_cnt_d >= TIMEOUT_C) begin
            mem_err_d = 1'b1;
         end
      end else begin
         state_d    = RUN;
         wait_cnt_d = '0;
         if (state_q == RUN) begin
            if (hz.PCtaken_E) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
            end else if (load_use) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end
      end
   end

   // Drive the pipeline-facing outputs; forwarding is forced to the register file in reset
   always_comb begin
      hz.Stall_F    = stall_f;
      hz.Stall_D    = stall_d;
      hz.Stall_E    = stall_e;
      hz.Stall_M    = stall_m;
      hz.Flush_D    = flush_d;
      hz.Flush_E    = flush_e;
      hz.Flush_W    = flush_w;
      hz.ForwardA_E = rst ? FWD_RF : fwd_a;
      hz.ForwardB_E = rst ? FWD_RF : fwd_b;
      hz.MemErr     = mem_err_q;
   end

`ifdef HAZARD_PERF_EN
   logic [WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   // Count stall cycles and front-end flush cycles; Flush_W alone is not counted
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_f || stall_d || stall_e || stall_m) begin
         stall_cnt_d = stall_cnt_q + WIDTH'(1);
      end
      if (flush_d || flush_e) begin
         flush_cnt_d = flush_cnt_q + WIDTH'(1);
      end
   end

   // Counter registers; reset cycles clear rather than count
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Expose the counters
   always_comb begin
      hz.StallCnt = stall_cnt_q;
      hz.FlushCnt = flush_cnt_q;
   end
`else
   // Counters not built in this configuration
   always_comb begin
      hz.StallCnt = {WIDTH{1'b0}};
      hz.FlushCnt = {WIDTH{1'b0}};
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a
// cycle-level reference model of the hazard rules.

module tb_hazard_ctrl;

   localparam int WIDTH       = 32;
   localparam int MEM_TIMEOUT = 16;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1d;
      logic [4:0] rs2d;
      logic [4:0] rs1e;
      logic [4:0] rs2e;
      logic [4:0] rde;
      logic [1:0] rsrc;
      logic       taken;
      logic [4:0] rdm;
      logic       rwm;
      logic       req;
      logic       ready;
      logic [4:0] rdw;
      logic       rww;
   } stim_t;

   logic clk = 1'b0;
   logic rst;

   hazard_ctrl_if #(.WIDTH(WIDTH)) hz ();

   hazard_ctrl #(
      .WIDTH       (WIDTH),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;

   // Model state: memory-wait tracking, sticky error, perf counts
   bit               mInWait;
   int               mWaitCycles;
   bit               mErr;
   logic [WIDTH-1:0] mStallCnt;
   logic [WIDTH-1:0] mFlushCnt;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic logic [1:0] expFwd(input logic [4:0] rs, input stim_t s);
      if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
      if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Drive one cycle, check every output against the model, then advance the model
   task automatic applyStimulus(input stim_t s);
      bit eSF, eSD, eSE, eSM, eFD, eFE, eFW, memStall, loadUse;
      logic [1:0] eFA, eFB;
      @(negedge clk);
      rst            = s.rst;
      hz.Rs1_D       = s.rs1d;
      hz.Rs2_D       = s.rs2d;
      hz.Rs1_E       = s.rs1e;
      hz.Rs2_E       = s.rs2e;
      hz.Rd_E        = s.rde;
      hz.ResultSrc_E = s.rsrc;
      hz.PCtaken_E   = s.taken;
      hz.Rd_M        = s.rdm;
      hz.RegWrite_M  = s.rwm;
      hz.MemReq_M    = s.req;
      hz.MemReady_M  = s.ready;
      hz.Rd_W        = s.rdw;
      hz.RegWrite_W  = s.rww;
      #2;
      {eSF, eSD, eSE, eSM, eFD, eFE, eFW} = '0;
      memStall = s.req && !s.ready;
      loadUse  = s.rsrc == 2'b01 && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
      eFA = s.rst ? 2'b00 : expFwd(s.rs1e, s);
      eFB = s.rst ? 2'b00 : expFwd(s.rs2e, s);
      if (s.rst) begin
         {eFD, eFE, eFW} = 3'b111;
      end else if (memStall) begin
         {eSF, eSD, eSE, eSM, eFW} = 5'b11111;
      end else if (!mInWait) begin
         if (s.taken) {eFD, eFE} = 2'b11;
         else if (loadUse) {eSF, eSD, eFE} = 3'b111;
      end
      checkOutput("Stall_F", 64'(hz.Stall_F), 64'(eSF));
      checkOutput("Stall_D", 64'(hz.Stall_D), 64'(eSD));
      checkOutput("Stall_E", 64'(hz.Stall_E), 64'(eSE));
      checkOutput("Stall_M", 64'(hz.Stall_M), 64'(eSM));
      checkOutput("Flush_D", 64'(hz.Flush_D), 64'(eFD));
      checkOutput("Flush_E", 64'(hz.Flush_E), 64'(eFE));
      checkOutput("Flush_W", 64'(hz.Flush_W), 64'(eFW));
      checkOutput("ForwardA_E", 64'(hz.ForwardA_E), 64'(eFA));
      checkOutput("ForwardB_E", 64'(hz.ForwardB_E), 64'(eFB));
      checkOutput("MemErr", 64'(hz.MemErr), 64'(mErr));
`ifdef HAZARD_PERF_EN
      checkOutput("StallCnt", 64'(hz.StallCnt), 64'(mStallCnt));
      checkOutput("FlushCnt", 64'(hz.FlushCnt), 64'(mFlushCnt));
`else
      checkOutput("StallCnt", 64'(hz.StallCnt), 64'd0);
      checkOutput("FlushCnt", 64'(hz.FlushCnt), 64'd0);
`endif
      @(posedge clk);
      if (s.rst) begin
         mInWait     = 0;
         mWaitCycles = 0;
         mErr        = 0;
         mStallCnt   = '0;
         mFlushCnt   = '0;
      end else begin
         if (eSF || eSD || eSE || eSM) mStallCnt = mStallCnt + 1'b1;
         if (eFD || eFE) mFlushCnt = mFlushCnt + 1'b1;
         if (memStall) begin
            mWaitCycles = mInWait ? mWaitCycles + 1 : 1;
            mInWait     = 1;
            if (mWaitCycles >= MEM_TIMEOUT) mErr = 1;
         end else begin
            mInWait     = 0;
            mWaitCycles = 0;
         end
      end
   endtask

   initial begin
      stim_t s;
      int waitLeft;

      // Unchecked first reset edge brings every flop to a known value
      s = idle();
      s.rst = 1'b1;
      rst = 1'b1;
      {hz.Rs1_D, hz.Rs2_D, hz.Rs1_E, hz.Rs2_E, hz.Rd_E} = '0;
      {hz.ResultSrc_E, hz.PCtaken_E, hz.Rd_M, hz.RegWrite_M} = '0;
      {hz.MemReq_M, hz.MemReady_M, hz.Rd_W, hz.RegWrite_W} = '0;
      @(posedge clk);
      mInWait = 0; mWaitCycles = 0; mErr = 0; mStallCnt = '0; mFlushCnt = '0;
      applyStimulus(s);

      // Forwarding: MEM priority, then WB when MEM targets x0
      s = idle();
      s.rs1e = 5; s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5;
      applyStimulus(s);
      s.rdm = 0;
      applyStimulus(s);
      s.rs2e = 5; s.rdw = 0;
      applyStimulus(s);

      // Load-use: one bubble, then clear
      s = idle(); s.rst = 1; applyStimulus(s);
      s = idle();
      s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7;
      applyStimulus(s);
      s.rde = 0;
      applyStimulus(s);
      applyStimulus(idle());

      // Branch together with load-use: flush only
      s = idle();
      s.rsrc = 2'b01; s.rde = 7; s.rs1d = 7; s.taken = 1;
      applyStimulus(s);

      // Three-cycle memory wait, then completion
      s = idle(); s.rst = 1; applyStimulus(s);
      s = idle(); s.req = 1; s.ready = 0;
      repeat (3) applyStimulus(s);
      s.ready = 1;
      applyStimulus(s);
      applyStimulus(idle());

      // Twenty-cycle wait trips the timeout; reset clears it
      s = idle(); s.req = 1; s.ready = 0;
      repeat (20) applyStimulus(s);
      s = idle(); s.rst = 1; applyStimulus(s);
      applyStimulus(idle());

      // Randomized traffic with occasional long memory waits and resets
      waitLeft = 0;
      for (int i = 0; i < 600; i++) begin
         s.rst   = ($urandom_range(0, 79) == 0);
         s.rs1d  = 5'($urandom_range(0, 3));
         s.rs2d  = 5'($urandom_range(0, 3));
         s.rs1e  = 5'($urandom_range(0, 3));
         s.rs2e  = 5'($urandom_range(0, 3));
         s.rde   = 5'($urandom_range(0, 3));
         s.rsrc  = 2'($urandom_range(0, 3));
         s.taken = ($urandom_range(0, 5) == 0);
         s.rdm   = 5'($urandom_range(0, 3));
         s.rwm   = 1'($urandom);
         s.rdw   = 5'($urandom_range(0, 3));
         s.rww   = 1'($urandom);
         if (waitLeft > 0) begin
            s.req = 1; s.ready = 0; waitLeft--;
         end else begin
            s.req   = ($urandom_range(0, 3) == 0);
            s.ready = 1'($urandom);
            if ($urandom_range(0, 39) == 0) waitLeft = $urandom_range(1, 22);
         end
         applyStimulus(s);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
